// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between request sources and the priority arbiter.
interface priority_arbiter_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     mask;
  logic             ack;
  logic             valid;
  logic [IDX_W-1:0] index;
  logic [N-1:0]     pending;

  // Request side: drives requests/mask/ack, observes the grant.
  modport master (
    output req,
    output mask,
    output ack,
    input  valid,
    input  index,
    input  pending
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  mask,
    input  ack,
    output valid,
    output index,
    output pending
  );
endinterface

// File: rtl/priority_arbiter.sv
// Registered priority encoder with sticky requests, masking, valid/ack grant
// handshake and optional rotating priority.
module priority_arbiter #(
  parameter int unsigned N           = 8,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  priority_arbiter_if.slave bus
);
  localparam int unsigned      IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [N-1:0]     ONE   = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]     pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             accept;
  logic [N-1:0]     clr;
  logic [N-1:0]     elig;
  logic             found;
  logic [IDX_W-1:0] winner;
  int unsigned      cand;

  // Next pending set, pointer update, winner scan and grant register load.
  always_comb begin
    accept    = valid_q & bus.ack;
    clr       = '0;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    index_d   = index_q;
    found     = 1'b0;
    winner    = '0;
    cand      = 0;

    if (accept) begin
      clr = ONE << index_q;
    end
    // Set beats clear: a re-request on the acked line keeps it pending.
    pending_d = (pending_q & ~clr) | bus.req;
    elig      = pending_d & ~bus.mask;

    // The scan for the next grant already starts below the line just served.
    if (ROUND_ROBIN && accept) begin
      ptr_d = (index_q == '0) ? LAST : index_q - IDX_W'(1);
    end

    // Descending scan from ptr_d, wrapping to N-1 below 0.
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_d) >= i) ? 32'(ptr_d) - i : 32'(ptr_d) + N - i;
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end

    // An outstanding grant is never retracted; it only moves on accept.
    if (!valid_q || accept) begin
      valid_d = found;
      index_d = found ? winner : '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      ptr_q     <= LAST;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.index   = index_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: three instances (N=8 fixed, N=8 round robin,
// N=5 round robin) share one stimulus stream and are compared each cycle
// against a per-instance reference model, plus hand-derived directed values.
module tb_priority_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  priority_arbiter_if #(.N(8)) if_fix ();
  priority_arbiter_if #(.N(8)) if_rr ();
  priority_arbiter_if #(.N(5)) if_5 ();

  assign if_fix.req  = req;
  assign if_fix.mask = mask;
  assign if_fix.ack  = ack;
  assign if_rr.req   = req;
  assign if_rr.mask  = mask;
  assign if_rr.ack   = ack;
  assign if_5.req    = req[4:0];
  assign if_5.mask   = mask[4:0];
  assign if_5.ack    = ack;

  priority_arbiter #(.N(8), .ROUND_ROBIN(1'b0)) u_fix (.clk(clk), .reset(reset), .bus(if_fix));
  priority_arbiter #(.N(8), .ROUND_ROBIN(1'b1)) u_rr  (.clk(clk), .reset(reset), .bus(if_rr));
  priority_arbiter #(.N(5), .ROUND_ROBIN(1'b1)) u_5   (.clk(clk), .reset(reset), .bus(if_5));

  // Reference model state, one slot per instance.
  int       n_of  [3] = '{8, 8, 5};
  bit       rr_of [3] = '{1'b0, 1'b1, 1'b1};
  bit [7:0] mp    [3];
  bit       mv    [3];
  int       mi    [3];
  int       mptr  [3];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock of the arbiter's rules in plain integer arithmetic.
  task automatic model_step(input int m, input bit rst, input bit [7:0] r_in,
                            input bit [7:0] mk_in, input bit a);
    bit [7:0] lim, r, mk, pn, el;
    bit       acc;
    int       sp, w, c;
    lim = 8'((1 << n_of[m]) - 1);
    r   = r_in & lim;
    mk  = mk_in & lim;
    if (rst) begin
      mp[m] = '0; mv[m] = 1'b0; mi[m] = 0; mptr[m] = n_of[m] - 1;
      return;
    end
    acc = mv[m] && a;
    pn  = mp[m];
    if (acc) pn[mi[m]] = 1'b0;
    pn = pn | r;
    el = pn & ~mk;
    sp = mptr[m];
    if (acc && rr_of[m]) sp = (mi[m] + n_of[m] - 1) % n_of[m];
    if (!mv[m] || acc) begin
      w = -1;
      for (int k = 0; k < n_of[m]; k++) begin
        c = (sp - k + n_of[m]) % n_of[m];
        if (w < 0 && el[c]) w = c;
      end
      mv[m] = (w >= 0);
      mi[m] = (w >= 0) ? w : 0;
    end
    mp[m]   = pn;
    mptr[m] = sp;
  endtask

  task automatic cmp_one(input string nm, input int m, input logic v,
                         input logic [7:0] idx, input logic [7:0] pend);
    check({nm, ".valid"},   32'(v),    32'(mv[m]));
    check({nm, ".index"},   32'(idx),  32'(mi[m]));
    check({nm, ".pending"}, 32'(pend), 32'(mp[m]));
  endtask

  // Advance one cycle: models follow the edge, DUTs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_step(m, reset, req, mask, ack);
    #1;
    cmp_one("fix", 0, if_fix.valid, 8'(if_fix.index), 8'(if_fix.pending));
    cmp_one("rr",  1, if_rr.valid,  8'(if_rr.index),  8'(if_rr.pending));
    cmp_one("n5",  2, if_5.valid,   8'(if_5.index),   8'(if_5.pending));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; mask = '0; ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int exp_rr [6] = '{7, 4, 0, 7, 4, 0};

  initial begin
    reset = 1'b1; req = '0; mask = '0; ack = 1'b0;

    // Reset state.
    do_reset();
    check("rst.valid",   32'(if_fix.valid),   0);
    check("rst.index",   32'(if_fix.index),   0);
    check("rst.pending", 32'(if_fix.pending), 0);

    // Fixed priority: two requests drained highest first.
    req = 8'b0010_0100; ack = 1'b1; step();
    check("fp.t1.index", 32'(if_fix.index), 5);
    req = '0; step();
    check("fp.t2.index", 32'(if_fix.index), 2);
    step();
    check("fp.t3.valid",   32'(if_fix.valid),   0);
    check("fp.t3.index",   32'(if_fix.index),   0);
    check("fp.t3.pending", 32'(if_fix.pending), 0);

    // Hold: no retraction for a higher line while unacked.
    do_reset();
    req = 8'h01; ack = 1'b0; step();
    check("hold.first", 32'(if_fix.index), 0);
    req = 8'h80; step();
    check("hold.keep",    32'(if_fix.index),   0);
    check("hold.pending", 32'(if_fix.pending), 32'h81);
    req = '0; ack = 1'b1; step();
    check("hold.next", 32'(if_fix.index), 7);
    step();

    // Mask: masked line stays pending, granted after unmask.
    do_reset();
    mask = 8'h80; req = 8'h81; ack = 1'b1; step();
    check("mask.idx0", 32'(if_fix.index), 0);
    req = '0; step();
    check("mask.valid0",  32'(if_fix.valid),   0);
    check("mask.pending", 32'(if_fix.pending), 32'h80);
    mask = '0; step();
    check("mask.valid1", 32'(if_fix.valid), 1);
    check("mask.idx7",   32'(if_fix.index), 7);
    step();

    // Round robin vs fixed with held requests.
    do_reset();
    req = 8'h91; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr.seq%0d", i), 32'(if_rr.index), 32'(exp_rr[i]));
      check($sformatf("fix.seq%0d", i), 32'(if_fix.index), 7);
    end
    req = '0;
    repeat (4) step();

    // Set beats clear on the acked line.
    do_reset();
    req = 8'h08; ack = 1'b0; step();
    check("sbc.idx", 32'(if_fix.index), 3);
    ack = 1'b1; step();
    check("sbc.pend3", 32'(if_fix.pending[3]), 1);
    check("sbc.regrant", 32'(if_fix.index), 3);
    req = '0; repeat (2) step();

    // Reset mid-operation restores the round-robin pointer.
    do_reset();
    req = 8'h08; ack = 1'b0; step();
    req = 8'hFF; ack = 1'b1; step();
    check("mid.pre.pending", 32'(if_rr.pending), 32'hFF);
    check("mid.pre.index",   32'(if_rr.index),   2);
    reset = 1'b1; step();
    check("mid.rst.pending", 32'(if_rr.pending), 0);
    check("mid.rst.valid",   32'(if_rr.valid),   0);
    check("mid.rst.index",   32'(if_rr.index),   0);
    reset = 1'b0; req = 8'h05; ack = 1'b0; step();
    check("mid.first", 32'(if_rr.index), 2);

    // Non-power-of-two width: top line is 4.
    do_reset();
    req = 8'hFF; step();
    check("n5.top", 32'(if_5.index), 4);
    req = '0;

    // Randomized traffic against the models.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack   = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
